// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a byte source and the PS/2 host transmitter.
// The source owns valid/data; the transmitter owns ready, completion and busy.
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       busy;

   modport master (output tx_valid, output tx_data,
                   input  tx_ready, input tx_done, input tx_error, input busy);
   modport slave  (input  tx_valid, input tx_data,
                   output tx_ready, output tx_done, output tx_error, output busy);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start request, device-clocked
// data/parity/stop, ACK check and bus-idle wait, with first-edge/bit timeouts.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES     = 10000,
   parameter int FIRST_EDGE_TIMEOUT = 1500000,
   parameter int BIT_TIMEOUT        = 200000,
   parameter int FILTER_LEN         = 8
) (
   input  logic         clk,
   input  logic         rst,
   ps2_host_tx_if.slave cmd,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_drive_low,
   output logic         ps2_data_drive_low
);

   localparam int CNT_MAX_A = (FIRST_EDGE_TIMEOUT > BIT_TIMEOUT) ? FIRST_EDGE_TIMEOUT : BIT_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > INHIBIT_CYCLES) ? CNT_MAX_A : INHIBIT_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] FE_LAST   = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_IDLE = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERR       = 3'd6
   } state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   logic [1:0]            clk_sync_r, data_sync_r;
   logic [FILTER_LEN-1:0] clk_sh_r;
   logic                  clk_filt_r, clk_filt_d_r;
   logic                  fall_s, data_s;

   state_t           state_r, state_n;
   logic [CNT_W-1:0] cnt_r, cnt_n, cnt_inc_s;
   logic [3:0]       bitcnt_r, bitcnt_n;
   logic [10:0]      frame_r, frame_n;
   logic             ready_r, done_r, error_r, busy_r, clk_drv_r, data_drv_r;
   logic             data_drv_n;

   // Synchronize both lines and debounce the clock line
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_r   <= 2'b11;
         data_sync_r  <= 2'b11;
         clk_sh_r     <= {FILTER_LEN{1'b1}};
         clk_filt_r   <= 1'b1;
         clk_filt_d_r <= 1'b1;
      end else begin
         clk_sync_r   <= {clk_sync_r[0], ps2_clk_in};
         data_sync_r  <= {data_sync_r[0], ps2_data_in};
         clk_sh_r     <= {clk_sh_r[FILTER_LEN-2:0], clk_sync_r[1]};
         clk_filt_d_r <= clk_filt_r;
         if (&clk_sh_r) begin
            clk_filt_r <= 1'b1;
         end else if (~|clk_sh_r) begin
            clk_filt_r <= 1'b0;
         end else begin
            clk_filt_r <= clk_filt_r;
         end
      end
   end

   assign fall_s    = clk_filt_d_r & ~clk_filt_r;
   assign data_s    = data_sync_r[1];
   assign cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

   // Next-state, counter, bit index and frame computation
   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_inc_s;
      bitcnt_n = bitcnt_r;
      frame_n  = frame_r;
      case (state_r)
         ST_IDLE: begin
            cnt_n = CNT_ZERO;
            if (cmd.tx_valid && ready_r) begin
               state_n = ST_INHIBIT;
               frame_n = {1'b1, odd_parity(cmd.tx_data), cmd.tx_data, 1'b0};
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_INHIBIT: begin
            if (cnt_r == INH_LAST) begin
               state_n = ST_REQ;
            end else begin
               state_n = ST_INHIBIT;
            end
         end
         ST_REQ: begin
            state_n  = ST_SEND;
            bitcnt_n = 4'd0;
            cnt_n    = CNT_ZERO;
         end
         ST_SEND: begin
            // Data advances on each device fall, so it settles while the clock is low
            if (fall_s) begin
               cnt_n = CNT_ZERO;
               if (bitcnt_r == 4'd10) begin
                  state_n = data_s ? ST_ERR : ST_WAIT_IDLE;
               end else begin
                  bitcnt_n = bitcnt_r + 4'd1;
               end
            end else if ((bitcnt_r == 4'd0) && (cnt_r == FE_LAST)) begin
               state_n = ST_ERR;
            end else if ((bitcnt_r != 4'd0) && (cnt_r == BIT_LAST)) begin
               state_n = ST_ERR;
            end else begin
               state_n = ST_SEND;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_filt_r && data_s) begin
               state_n = ST_DONE;
            end else if (cnt_r == BIT_LAST) begin
               state_n = ST_ERR;
            end else begin
               state_n = ST_WAIT_IDLE;
            end
         end
         ST_DONE:  state_n = ST_IDLE;
         ST_ERR:   state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Data line drive for the upcoming state
   always_comb begin
      data_drv_n = 1'b0;
      if (state_n == ST_REQ) begin
         data_drv_n = 1'b1;
      end else if (state_n == ST_SEND) begin
         data_drv_n = ~frame_n[bitcnt_n];
      end else begin
         data_drv_n = 1'b0;
      end
   end

   // State register with registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         bitcnt_r   <= 4'd0;
         frame_r    <= 11'd0;
         ready_r    <= 1'b1;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         busy_r     <= 1'b0;
         clk_drv_r  <= 1'b0;
         data_drv_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         bitcnt_r   <= bitcnt_n;
         frame_r    <= frame_n;
         ready_r    <= (state_n == ST_IDLE);
         done_r     <= (state_n == ST_DONE);
         error_r    <= (state_n == ST_ERR);
         busy_r     <= (state_n != ST_IDLE);
         clk_drv_r  <= (state_n == ST_INHIBIT) || (state_n == ST_REQ);
         data_drv_r <= data_drv_n;
      end
   end

   assign cmd.tx_ready       = ready_r;
   assign cmd.tx_done        = done_r;
   assign cmd.tx_error       = error_r;
   assign cmd.busy           = busy_r;
   assign ps2_clk_drive_low  = clk_drv_r;
   assign ps2_data_drive_low = data_drv_r;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard. It sits beside the keyboard receive path and shares the open-drain PS/2 clock and data lines with it. It runs the full host request sequence: line inhibit, start request, device-clocked data/parity/stop, and ACK check. It reports completion or error to the command source and asserts busy so the receive path can ignore the line meanwhile.

Parameters:
INHIBIT_CYCLES, 10000, clk cycles the host holds PS/2 clock low before the request (100 us at 100 MHz)
FIRST_EDGE_TIMEOUT, 1500000, max clk cycles from clock release to the first device falling edge (15 ms)
BIT_TIMEOUT, 200000, max clk cycles between consecutive device falling edges, and from ACK to bus idle (2 ms)
FILTER_LEN, 8, consecutive equal samples required to accept a new PS/2 clock level

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tx_valid  in  1  command byte available
tx_data  in  8  command byte
tx_ready  out  1  block idle and able to accept a byte
tx_done  out  1  one-cycle pulse: byte sent and ACKed
tx_error  out  1  one-cycle pulse: NACK or timeout
busy  out  1  high from acceptance until the done/error pulse, inclusive
ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous)
ps2_data_in  in  1  raw PS/2 data line level (asynchronous)
ps2_clk_drive_low  out  1  1 = pull PS/2 clock low; 0 = release
ps2_data_drive_low  out  1  1 = pull PS/2 data low; 0 = release

Behaviour:
- One clock domain: clk. Reset: synchronous, active-high on rst, sampled on the rising clk edge.
- Reset values: state IDLE, tx_ready=1, tx_done=0, tx_error=0, busy=0, both drive_low=0. Filter and sync registers reset to 1.
- Reset mid-frame: lines are released and state is IDLE on the first clk edge with rst=1. No done/error pulse is generated.
- Input conditioning:
  - Both line inputs pass through a 2-FF synchronizer.
  - The clock line also passes through a FILTER_LEN shift filter. The filtered level changes only when all FILTER_LEN samples agree.
  - fall = one-cycle pulse on a filtered 1->0 transition.
- Handshake:
  - A byte is accepted on the cycle where tx_valid=1 and tx_ready=1. tx_data is latched then.
  - Odd parity is computed: parity = ~^tx_data.
  - tx_ready drops the next cycle. tx_valid while busy is ignored.
- FSM:
  - IDLE: tx_ready=1. On accept, go to INHIBIT and clear the counter.
  - INHIBIT: clk_drive_low=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: exactly 1 cycle with clk_drive_low=1 and data_drive_low=1 (start bit). Then go to SEND with bitcnt=0 and the counter cleared.
  - SEND:
    - clk_drive_low=0. data_drive_low = ~frame[bitcnt].
    - frame = {stop=1, parity, d7..d0, start=0}, bit index 0 = start.
    - On each fall: bitcnt increments and the counter clears. Data therefore changes while the device holds clock low.
    - Falls 1-8 present d0..d7, fall 9 presents parity, fall 10 presents stop (data released).
    - Fall 11 samples synchronized ps2_data_in: 0 goes to WAIT_IDLE, 1 goes to ERR (NACK).
  - WAIT_IDLE: both lines released. When filtered clock=1 and data=1, go to DONE.
  - DONE: 1 cycle with tx_done=1, then IDLE.
  - ERR: 1 cycle with tx_error=1 and both lines released, then IDLE.
- Timeouts (counter saturates, never wraps):
  - SEND with bitcnt=0: FIRST_EDGE_TIMEOUT cycles without a fall goes to ERR.
  - SEND with bitcnt>0, and WAIT_IDLE: BIT_TIMEOUT cycles without progress goes to ERR.
- busy = state != IDLE. tx_done and tx_error are never high together.
- Frame length is fixed at 11 device clocks. Extra falls after fall 11 are ignored.

Test Plan:
(Bench settings: INHIBIT_CYCLES=20, FILTER_LEN=2, FIRST_EDGE_TIMEOUT=400, BIT_TIMEOUT=100. A device model clocks at 40-cycle half-periods and drives ACK.)
- Send 0xED -> clock held low 20 cycles, then start 0. Bits on falls 1-8 are 1,0,1,1,0,1,1,1, parity 1, stop released. ACK=0 -> single tx_done pulse; tx_ready=1 the next cycle.
- Send 0x07, 0x00, 0xFF -> parity bits 0, 1, 1 respectively; each ends in tx_done.
- Device leaves data high on fall 11 -> tx_error pulse, no tx_done, both drive_low=0.
- Device never clocks -> tx_error exactly 400 cycles after REQ exits; lines released.
- rst asserted after fall 4 -> both drive_low=0 and tx_ready=1 on the next edge. No pulse; the next byte is sent cleanly.
- tx_valid pulsed while busy -> ignored, only the first byte is transmitted. A 1-cycle clock glitch is not counted as a fall.
